// File: rtl/z80_bus_pkg.sv
// Shared types for the tv80s bus responder.
//   cyc_t         : bus cycle classification, decoded from the strobes
//   wst_t         : wait-state FSM states
//   trace_entry_t : one committed bus write as kept in the trace FIFO
//   decode_cycle  : strobe decode; refresh and idle bus map to CYC_NONE
package z80_bus_pkg;

    // The Z80 address bus is 16 bits, so trace entries carry at most that.
    localparam int MAX_ADDR_W = 16;

    typedef enum logic [2:0] {
        CYC_NONE,
        CYC_MEM_RD,
        CYC_MEM_WR,
        CYC_IO_RD,
        CYC_IO_WR,
        CYC_INTACK
    } cyc_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD
    } wst_t;

    typedef struct packed {
        logic [MAX_ADDR_W-1:0] addr;
        logic [7:0]            data;
        logic                  is_io;
    } trace_entry_t;

    // IORQ with M1 is an interrupt acknowledge. MREQ with neither RD nor WR
    // is a refresh cycle and is deliberately not a cycle start.
    function automatic cyc_t decode_cycle(input logic mreq_n, input logic iorq_n,
                                          input logic rd_n, input logic wr_n,
                                          input logic m1_n);
        cyc_t c;
        c = CYC_NONE;
        if (!iorq_n && !m1_n)
            c = CYC_INTACK;
        else if (!iorq_n && !wr_n)
            c = CYC_IO_WR;
        else if (!iorq_n && !rd_n)
            c = CYC_IO_RD;
        else if (!mreq_n && !wr_n)
            c = CYC_MEM_WR;
        else if (!mreq_n && !rd_n)
            c = CYC_MEM_RD;
        return c;
    endfunction

endpackage

// File: rtl/z80_trace_fifo.sv
// Synchronous FIFO holding committed bus writes.
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write push_entry (dropped and ovf set if full with no pop)
//   pop         : remove head; ignored while empty
//   valid, head : FIFO not empty / oldest entry
//   count       : occupancy, 0..DEPTH
//   ovf         : sticky drop flag, cleared only by reset
module z80_trace_fifo
    import z80_bus_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  trace_entry_t             push_entry,
    input  logic                     pop,
    output logic                     valid,
    output trace_entry_t             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    trace_entry_t     store [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             ovf_q;
    logic             full, pop_ok, push_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign pop_ok  = pop && (count_q != '0);
    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // still succeeds then.
    assign push_ok = push && (!full || pop_ok);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
            if (push && !push_ok)
                ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            store[wr_ptr_q] <= push_entry;
    end

    assign valid = (count_q != '0);
    assign head  = store[rd_ptr_q];
    assign count = count_q;
    assign ovf   = ovf_q;

endmodule

// File: rtl/z80_bus_responder.sv
// Memory/IO responder for the tv80s bus with per-cycle-type wait states.
//   clk, reset_n         : CPU clock (bus used on both edges), async active-low reset
//   cpu_a, cpu_do, cpu_di: address, write data, registered read data
//   mreq_n..m1_n         : tv80s strobes; wait_n: wait request to the CPU
//   bd_we/bd_addr/bd_data: backdoor memory write for preloading
//   trace_*              : FIFO of committed writes (head, occupancy, overflow)
module z80_bus_responder
    import z80_bus_pkg::*;
#(
    parameter int         ADDR_W      = 16,
    parameter int         IO_ADDR_W   = 8,
    parameter int         MEM_WAIT    = 0,
    parameter int         IO_WAIT     = 1,
    parameter logic [7:0] INTACK_VEC  = 8'hFF,
    parameter int         TRACE_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [ADDR_W-1:0]            cpu_a,
    input  logic [7:0]                   cpu_do,
    output logic [7:0]                   cpu_di,
    input  logic                         mreq_n,
    input  logic                         iorq_n,
    input  logic                         rd_n,
    input  logic                         wr_n,
    input  logic                         m1_n,
    output logic                         wait_n,
    input  logic                         bd_we,
    input  logic [ADDR_W-1:0]            bd_addr,
    input  logic [7:0]                   bd_data,
    output logic                         trace_valid,
    input  logic                         trace_ready,
    output logic [ADDR_W-1:0]            trace_addr,
    output logic [7:0]                   trace_data,
    output logic                         trace_is_io,
    output logic [$clog2(TRACE_DEPTH):0] trace_count,
    output logic                         trace_ovf
);
    localparam logic [3:0] MEM_WAIT_C = 4'(MEM_WAIT);
    localparam logic [3:0] IO_WAIT_C  = 4'(IO_WAIT);

    logic [7:0] mem [2**ADDR_W];
    logic [7:0] io  [2**IO_ADDR_W];

    wst_t         state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    cyc_t         cyc_q, cyc_d;
    logic         done_q, done_d;
    cyc_t         cyc_now;
    logic         cyc_is_io, commit, commit_is_io;
    trace_entry_t push_entry, head;

    assign cyc_now      = decode_cycle(mreq_n, iorq_n, rd_n, wr_n, m1_n);
    assign cyc_is_io    = (cyc_now == CYC_IO_RD) || (cyc_now == CYC_IO_WR) ||
                          (cyc_now == CYC_INTACK);
    assign commit_is_io = (cyc_q == CYC_IO_RD) || (cyc_q == CYC_IO_WR);
    // done_q makes the write a single event per cycle even though wr_n
    // stays low across several rising edges.
    assign commit       = (state_q == HOLD) && !wr_n && !done_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cyc_q   <= CYC_NONE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cyc_d   = cyc_q;
        done_d  = done_q;
        case (state_q)
            IDLE: begin
                done_d = 1'b0;
                if (cyc_now != CYC_NONE) begin
                    cyc_d   = cyc_now;
                    cnt_d   = cyc_is_io ? IO_WAIT_C : MEM_WAIT_C;
                    state_d = (cnt_d == 4'd0) ? HOLD : WAIT;
                end
            end
            WAIT: begin
                // wait_n is low for the whole WAIT dwell: N clocks for cnt=N.
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                if (commit)
                    done_d = 1'b1;
                if (mreq_n && iorq_n)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wait_n = (state_q != WAIT);
    end

    // Bus write is assigned last so it wins over a same-address backdoor write.
    always_ff @(posedge clk) begin
        if (bd_we)
            mem[bd_addr] <= bd_data;
        if (commit && !commit_is_io)
            mem[cpu_a] <= cpu_do;
    end

    always_ff @(posedge clk) begin
        if (commit && commit_is_io)
            io[cpu_a[IO_ADDR_W-1:0]] <= cpu_do;
    end

    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n)
            cpu_di <= 8'h00;
        else if (!iorq_n && !m1_n)
            cpu_di <= INTACK_VEC;
        else if (!iorq_n)
            cpu_di <= io[cpu_a[IO_ADDR_W-1:0]];
        else
            cpu_di <= mem[cpu_a];
    end

    assign push_entry.addr  = MAX_ADDR_W'(cpu_a);
    assign push_entry.data  = cpu_do;
    assign push_entry.is_io = commit_is_io;

    z80_trace_fifo #(
        .DEPTH (TRACE_DEPTH)
    ) u_trace_fifo (
        .clk        (clk),
        .rst_n      (reset_n),
        .push       (commit),
        .push_entry (push_entry),
        .pop        (trace_valid && trace_ready),
        .valid      (trace_valid),
        .head       (head),
        .count      (trace_count),
        .ovf        (trace_ovf)
    );

    assign trace_addr  = head.addr[ADDR_W-1:0];
    assign trace_data  = head.data;
    assign trace_is_io = head.is_io;

endmodule

// File: tb/tb_z80_bus_responder.sv
// Directed bench: two responders (MEM_WAIT=0 and MEM_WAIT=2), each with its
// own emulated tv80s bus, sharing clock, reset and the backdoor port.
module tb_z80_bus_responder;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] cpu_a [2];
    logic [7:0]  cpu_do [2];
    logic [7:0]  cpu_di [2];
    logic        mreq_n [2], iorq_n [2], rd_n [2], wr_n [2], m1_n [2];
    logic        wait_n [2];
    logic        trace_valid [2], trace_ready [2], trace_is_io [2], trace_ovf [2];
    logic [15:0] trace_addr [2];
    logic [7:0]  trace_data [2];
    logic [4:0]  trace_count [2];
    logic        bd_we;
    logic [15:0] bd_addr;
    logic [7:0]  bd_data;

    z80_bus_responder #(
        .ADDR_W(16), .IO_ADDR_W(8), .MEM_WAIT(0), .IO_WAIT(1),
        .INTACK_VEC(8'hFF), .TRACE_DEPTH(16)
    ) dut0 (
        .clk(clk), .reset_n(reset_n), .cpu_a(cpu_a[0]), .cpu_do(cpu_do[0]),
        .cpu_di(cpu_di[0]), .mreq_n(mreq_n[0]), .iorq_n(iorq_n[0]), .rd_n(rd_n[0]),
        .wr_n(wr_n[0]), .m1_n(m1_n[0]), .wait_n(wait_n[0]), .bd_we(bd_we),
        .bd_addr(bd_addr), .bd_data(bd_data), .trace_valid(trace_valid[0]),
        .trace_ready(trace_ready[0]), .trace_addr(trace_addr[0]),
        .trace_data(trace_data[0]), .trace_is_io(trace_is_io[0]),
        .trace_count(trace_count[0]), .trace_ovf(trace_ovf[0])
    );

    z80_bus_responder #(
        .ADDR_W(16), .IO_ADDR_W(8), .MEM_WAIT(2), .IO_WAIT(1),
        .INTACK_VEC(8'hFF), .TRACE_DEPTH(16)
    ) dut2 (
        .clk(clk), .reset_n(reset_n), .cpu_a(cpu_a[1]), .cpu_do(cpu_do[1]),
        .cpu_di(cpu_di[1]), .mreq_n(mreq_n[1]), .iorq_n(iorq_n[1]), .rd_n(rd_n[1]),
        .wr_n(wr_n[1]), .m1_n(m1_n[1]), .wait_n(wait_n[1]), .bd_we(bd_we),
        .bd_addr(bd_addr), .bd_data(bd_data), .trace_valid(trace_valid[1]),
        .trace_ready(trace_ready[1]), .trace_addr(trace_addr[1]),
        .trace_data(trace_data[1]), .trace_is_io(trace_is_io[1]),
        .trace_count(trace_count[1]), .trace_ovf(trace_ovf[1])
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic bus_idle(input int d);
        mreq_n[d] = 1'b1; iorq_n[d] = 1'b1; rd_n[d] = 1'b1;
        wr_n[d] = 1'b1; m1_n[d] = 1'b1;
    endtask

    task automatic bd_write(input logic [15:0] a, input logic [7:0] v);
        bd_we = 1'b1; bd_addr = a; bd_data = v;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    // Advance clocks until wait_n is released, counting clocks with wait_n low.
    task automatic wait_release(input int d, output int low, output int edges);
        low = 0; edges = 0;
        do begin
            @(posedge clk); #1;
            edges++;
            if (!wait_n[d]) low++;
        end while (!wait_n[d] && edges < 40);
        chk("wait_bound", wait_n[d], 1);
    endtask

    // kind: 0 mem read, 1 opcode fetch (M1), 2 IO read, 3 interrupt acknowledge
    task automatic bus_rd(input int d, input int kind, input logic [15:0] a,
                          output logic [7:0] v, output int low, output int edges);
        cpu_a[d] = a;
        if (kind <= 1) begin mreq_n[d] = 1'b0; rd_n[d] = 1'b0; end
        if (kind == 1) m1_n[d] = 1'b0;
        if (kind == 2) begin iorq_n[d] = 1'b0; rd_n[d] = 1'b0; end
        if (kind == 3) begin iorq_n[d] = 1'b0; m1_n[d] = 1'b0; end
        wait_release(d, low, edges);
        @(negedge clk); #1;
        v = cpu_di[d];
        bus_idle(d);
        @(posedge clk); #1;
        edges++;
    endtask

    task automatic bus_wr(input int d, input bit is_io, input logic [15:0] a,
                          input logic [7:0] v, input bit collide, input bit pop,
                          output int low, output int edges);
        cpu_a[d] = a; cpu_do[d] = v; wr_n[d] = 1'b0;
        if (is_io) iorq_n[d] = 1'b0; else mreq_n[d] = 1'b0;
        wait_release(d, low, edges);
        if (collide) begin bd_we = 1'b1; bd_addr = a; bd_data = ~v; end
        if (pop) trace_ready[d] = 1'b1;
        @(posedge clk); #1;
        edges++;
        bd_we = 1'b0; trace_ready[d] = 1'b0;
        bus_idle(d);
        @(posedge clk); #1;
        edges++;
    endtask

    task automatic pop_chk(input int d, input string tag, input logic [15:0] a,
                           input logic [7:0] v, input logic io_f);
        chk({tag, "_valid"}, trace_valid[d], 1);
        chk({tag, "_addr"}, trace_addr[d], a);
        chk({tag, "_data"}, trace_data[d], v);
        chk({tag, "_io"}, trace_is_io[d], io_f);
        trace_ready[d] = 1'b1;
        @(posedge clk); #1;
        trace_ready[d] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [7:0] v;
    int low, edges, tot;
    logic [15:0] prog_a [5];
    logic [7:0]  prog_v [5];
    int          prog_k [5];

    initial begin
        for (int d = 0; d < 2; d++) begin
            bus_idle(d);
            cpu_a[d] = '0; cpu_do[d] = '0; trace_ready[d] = 1'b0;
        end
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        prog_a = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h535F};
        prog_v = '{8'hDD, 8'hCB, 8'hE9, 8'hCD, 8'h1C};
        prog_k = '{1, 1, 0, 0, 0};

        // Preload while reset is held; memory contents are not reset.
        for (int i = 0; i < 5; i++) bd_write(prog_a[i], prog_v[i]);
        bd_write(16'h1234, 8'h77);
        for (int d = 0; d < 2; d++) begin
            chk("rst_cpu_di", cpu_di[d], 8'h00);
            chk("rst_wait_n", wait_n[d], 1);
            chk("rst_trace_valid", trace_valid[d], 0);
            chk("rst_trace_count", trace_count[d], 0);
            chk("rst_trace_ovf", trace_ovf[d], 0);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;

        // SET 1,(IX-23) with IX=5376: four fetch/operand reads, RMW at 535F.
        for (int d = 0; d < 2; d++) begin
            tot = 0;
            for (int i = 0; i < 5; i++) begin
                bus_rd(d, prog_k[i], prog_a[i], v, low, edges);
                chk("prog_rd_data", v, prog_v[i]);
                chk("prog_rd_wait", low, (d == 0) ? 0 : 2);
                tot += edges;
            end
            bus_wr(d, 1'b0, 16'h535F, 8'h1E, 1'b0, 1'b0, low, edges);
            chk("prog_wr_wait", low, (d == 0) ? 0 : 2);
            tot += edges;
            chk("prog_clocks", tot, (d == 0) ? 13 : 25);
            chk("prog_trace_count", trace_count[d], 1);
            chk("prog_trace_addr", trace_addr[d], 16'h535F);
            chk("prog_trace_data", trace_data[d], 8'h1E);
            chk("prog_trace_io", trace_is_io[d], 0);
            bus_rd(d, 0, 16'h535F, v, low, edges);
            chk("prog_mem_535f", v, 8'h1E);
        end

        // Refresh must not start a cycle (visible on the MEM_WAIT=2 unit).
        cpu_a[1] = 16'h0040; mreq_n[1] = 1'b0;
        @(posedge clk); #1;
        chk("refresh_wait_n", wait_n[1], 1);
        bus_idle(1);
        @(posedge clk); #1;

        // OUT (7Fh),A with A=5A, then read back, then interrupt acknowledge.
        bus_wr(0, 1'b1, 16'h007F, 8'h5A, 1'b0, 1'b0, low, edges);
        chk("io_wr_wait", low, 1);
        chk("io_trace_count", trace_count[0], 2);
        pop_chk(0, "pop_mem", 16'h535F, 8'h1E, 1'b0);
        pop_chk(0, "pop_io", 16'h007F, 8'h5A, 1'b1);
        chk("io_drained", trace_count[0], 0);
        bus_rd(0, 2, 16'h007F, v, low, edges);
        chk("io_rd_data", v, 8'h5A);
        chk("io_rd_wait", low, 1);
        bus_rd(0, 3, 16'h0038, v, low, edges);
        chk("intack_vec", v, 8'hFF);

        // Bus write and backdoor write to one address on the same edge.
        bus_wr(0, 1'b0, 16'h4000, 8'h3C, 1'b1, 1'b0, low, edges);
        bus_rd(0, 0, 16'h4000, v, low, edges);
        chk("collide_bus_wins", v, 8'h3C);
        pop_chk(0, "pop_collide", 16'h4000, 8'h3C, 1'b0);
        bd_write(16'h4001, 8'h99);
        bus_rd(0, 0, 16'h4001, v, low, edges);
        chk("backdoor_rd", v, 8'h99);
        chk("backdoor_no_trace", trace_count[0], 0);

        // Fill, push+pop while full, then overflow drop.
        for (int i = 0; i < 16; i++)
            bus_wr(0, 1'b0, 16'h2000 + 16'(i), 8'h10 + 8'(i), 1'b0, 1'b0, low, edges);
        chk("full_count", trace_count[0], 16);
        chk("full_ovf", trace_ovf[0], 0);
        bus_wr(0, 1'b0, 16'h2010, 8'h20, 1'b0, 1'b1, low, edges);
        chk("pushpop_count", trace_count[0], 16);
        chk("pushpop_ovf", trace_ovf[0], 0);
        chk("pushpop_head", trace_addr[0], 16'h2001);
        bus_wr(0, 1'b0, 16'h2011, 8'h21, 1'b0, 1'b0, low, edges);
        chk("ovf_count", trace_count[0], 16);
        chk("ovf_flag", trace_ovf[0], 1);
        chk("ovf_head", trace_addr[0], 16'h2001);
        bus_rd(0, 0, 16'h2011, v, low, edges);
        chk("ovf_mem_written", v, 8'h21);
        for (int i = 1; i <= 16; i++)
            pop_chk(0, "drain", 16'h2000 + 16'(i), 8'h10 + 8'(i), 1'b0);
        chk("drain_valid", trace_valid[0], 0);
        chk("drain_ovf_sticky", trace_ovf[0], 1);

        // Reset while wait_n is held low mid-write.
        cpu_a[1] = 16'h1234; cpu_do[1] = 8'hAA; mreq_n[1] = 1'b0; wr_n[1] = 1'b0;
        @(posedge clk); #1;
        chk("midrst_wait_low", wait_n[1], 0);
        reset_n = 1'b0;
        #1;
        chk("midrst_wait_n", wait_n[1], 1);
        chk("midrst_valid", trace_valid[1], 0);
        chk("midrst_ovf_clr", trace_ovf[0], 0);
        bus_idle(1);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("postrst_count", trace_count[1], 0);
        bus_rd(1, 0, 16'h1234, v, low, edges);
        chk("postrst_no_partial", v, 8'h77);
        chk("postrst_wait", low, 2);
        bus_wr(1, 1'b0, 16'h1234, 8'hBB, 1'b0, 1'b0, low, edges);
        chk("postrst_wr_wait", low, 2);
        chk("postrst_trace", trace_count[1], 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
